addr_mode_sequencer: RTL and testbench
======================================

ADDR_MODE_SEQUENCER -- requirements
Module: addr_mode_sequencer

Interface
REQ-001 Parameter PAGE_PENALTY, default 1: 1 = indexed reads insert FIX only on page cross; 0 = FIX always inserted (constant timing).
REQ-002 Parameter ZP_WRAP, default 1: 1 = zero-page indexed and pointer addresses wrap within page 0; 0 = carry propagates into the high byte (dirh_load asserted in ZPIDX).
REQ-003 clk  in  1  single clock, all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 opcode  in  8  data bus byte, sampled as opcode in FETCH.
REQ-006 rdy  in  1  1 = advance; 0 = stall current cycle.
REQ-007 page_cross  in  1  carry out of index add on low address byte, valid in the cycle after index_add.
REQ-008 instruction_load, increment_pc, dirl_load, dirh_load, indirl_load, indirh_load  out  1 each  register load/increment strobes.
REQ-009 index_add  out  1  add selected index to the low byte being loaded; index_sel  out  1  0 = X, 1 = Y.
REQ-010 dirh_inc  out  1  increment direct-high register (page fix); reg_load  out  1  load destination register from bus.
REQ-011 read_write  out  1  0 = read, 1 = write; address_select  out  2  0 PC, 1 ZERO, 2 ABS, 3 INDIR (zero-page pointer).
REQ-012 sync  out  1  high in FETCH only.

Function
REQ-013 In FETCH with rdy=1 the embedded decoder SHALL latch mode (IMP, IMM, ZP, ZPX, ZPY, ABS, ABSX, ABSY, INDX, INDY) and class (RD/WR) from opcode per the 6502 opcode matrix.
REQ-014 Cycle sequences after FETCH (all end returning to FETCH):
- IMM: IMM0.
- ZP: ZP0, EXEC.
- ZPX/ZPY: ZP0, ZPIDX, EXEC.
- ABS: ABS0, ABS1, EXEC.
- ABSX/ABSY: ABS0, ABS1, [FIX], EXEC.
- INDX: ZP0, IX1, IX2, IX3, EXEC.
- INDY: ZP0, IY1, IY2, [FIX], EXEC.
- IMP/undefined: FETCH back-to-back.
REQ-015 FIX SHALL be entered when class=WR, or PAGE_PENALTY=0, or page_cross=1; otherwise skipped.
REQ-016 Strobes per state:
- FETCH: instruction_load, increment_pc.
- IMM0: increment_pc, reg_load.
- ZP0: increment_pc; dirl_load (ZP/ZPX/ZPY) or indirl_load (INDX/INDY).
- ZPIDX: dirl_load+index_add.
- ABS0: dirl_load+increment_pc (+index_add for ABSX/ABSY).
- ABS1: dirh_load+increment_pc.
- IX1: indirl_load+index_add (X).
- IX2/IY1: dirl_load.
- IX3/IY2: dirh_load (+index_add Y on low in IY1).
- FIX: dirh_inc.
- EXEC: reg_load if RD.
REQ-017 address_select: PC in FETCH/IMM0/ZP0/ABS0/ABS1; ZERO in ZPIDX/IX1 (dummy read) and EXEC for ZP modes; INDIR in IX2/IX3/IY1/IY2; ABS in FIX and EXEC for ABS/IND modes.
REQ-018 read_write SHALL be 1 only in EXEC with class=WR; 0 elsewhere, including FIX.
REQ-019 index_sel SHALL be 1 for ZPY/ABSY/INDY, 0 otherwise.
REQ-020 rdy=0: state, mode and class held; all strobes forced 0; address_select and read_write hold state decode.
REQ-021 Outputs SHALL be decoded from state plus latched mode/class only (Moore); page_cross affects next state only.

Reset
REQ-022 rst low SHALL force state FETCH, mode IMP, class RD immediately.
REQ-023 Output values in reset: instruction_load=1, increment_pc=1, sync=1, address_select=0, all other outputs 0, with instruction_load and increment_pc gated to 0 when rdy=0.
REQ-024 Reset mid-instruction SHALL abandon the sequence; first edge after release fetches.

Structure
REQ-025 Shared package cpu_pkg SHALL hold state, mode, class and address_select enumerations.
REQ-026 Opcode-to-mode/class decoding SHALL be a sub-module addr_mode_decode (combinational); sequencing stays in this module.

Verification
REQ-027 opcode A9, rdy=1 -> FETCH, IMM0, FETCH; reg_load in cycle 2.
REQ-028 opcode BD, page_cross=0 -> 4 cycles (no FIX); page_cross=1 -> 5 cycles, dirh_inc in cycle 4.
REQ-029 opcode 9D (STA abs,X), page_cross=0 -> 5 cycles, read_write=1 only in cycle 5, address_select=2.
REQ-030 opcode A1 -> 6 cycles; address_select 3 in cycles 4-5; index_add with index_sel=0 in cycle 3.
REQ-031 opcode B1 with rdy=0 for 2 cycles in IY1 -> strobes 0 while stalled, total 8 cycles with page_cross=1.
REQ-032 rst pulsed low during IX2 -> state FETCH asynchronously, sync=1; next opcode A5 completes in 3 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the addressing-mode sequencer: FSM states, addressing modes,
// access class, address-select encoding and the bundle of register strobes.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_FETCH, ST_IMM0, ST_ZP0, ST_ZPIDX, ST_ABS0, ST_ABS1, ST_FIX,
        ST_IX1, ST_IX2, ST_IX3, ST_IY1, ST_IY2, ST_EXEC
    } state_t;

    typedef enum logic [3:0] {
        M_IMP, M_IMM, M_ZP, M_ZPX, M_ZPY, M_ABS, M_ABSX, M_ABSY, M_INDX, M_INDY
    } mode_t;

    typedef enum logic {CLS_RD, CLS_WR} op_class_t;

    typedef enum logic [1:0] {
        AS_PC = 2'd0, AS_ZERO = 2'd1, AS_ABS = 2'd2, AS_INDIR = 2'd3
    } addr_sel_t;

    typedef struct packed {
        logic instruction_load;
        logic increment_pc;
        logic dirl_load;
        logic dirh_load;
        logic indirl_load;
        logic indirh_load;
        logic index_add;
        logic dirh_inc;
        logic reg_load;
    } strobe_t;

    function automatic logic uses_y(input mode_t m);
        return (m == M_ZPY) || (m == M_ABSY) || (m == M_INDY);
    endfunction

endpackage

// File: rtl/addr_mode_sequencer_if.sv
// Opcode/stall/page-cross inputs and register-control strobes of the sequencer.
// master = sequencer side, slave = datapath side.
interface addr_mode_sequencer_if;
    logic [7:0] opcode;
    logic       rdy;
    logic       page_cross;
    logic       instruction_load;
    logic       increment_pc;
    logic       dirl_load;
    logic       dirh_load;
    logic       indirl_load;
    logic       indirh_load;
    logic       index_add;
    logic       index_sel;
    logic       dirh_inc;
    logic       reg_load;
    logic       read_write;
    logic [1:0] address_select;
    logic       sync;

    modport master (
        input  opcode, rdy, page_cross,
        output instruction_load, increment_pc, dirl_load, dirh_load, indirl_load,
               indirh_load, index_add, index_sel, dirh_inc, reg_load, read_write,
               address_select, sync
    );

    modport slave (
        output opcode, rdy, page_cross,
        input  instruction_load, increment_pc, dirl_load, dirh_load, indirl_load,
               indirh_load, index_add, index_sel, dirh_inc, reg_load, read_write,
               address_select, sync
    );
endinterface

// File: rtl/addr_mode_decode.sv
// Combinational 6502 opcode -> addressing mode / access class (zero latency).
// Unlisted opcodes (implied, branches, jumps, undocumented) decode as IMP.
module addr_mode_decode
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output mode_t      mode,
    output op_class_t  op_class
);
    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;

    assign aaa = opcode[7:5];
    assign bbb = opcode[4:2];
    assign cc  = opcode[1:0];

    always_comb begin
        mode     = M_IMP;
        op_class = (aaa == 3'b100) ? CLS_WR : CLS_RD;
        case (cc)
            2'b01: begin
                case (bbb)
                    3'b000:  mode = M_INDX;
                    3'b001:  mode = M_ZP;
                    3'b010:  mode = (aaa == 3'b100) ? M_IMP : M_IMM;
                    3'b011:  mode = M_ABS;
                    3'b100:  mode = M_INDY;
                    3'b101:  mode = M_ZPX;
                    3'b110:  mode = M_ABSY;
                    default: mode = M_ABSX;
                endcase
            end
            2'b00: begin
                case (bbb)
                    3'b000:  if (aaa[2] && aaa != 3'b100) mode = M_IMM;
                    3'b001:  if (aaa == 3'b001 || aaa[2]) mode = M_ZP;
                    3'b011:  if (aaa == 3'b001 || aaa[2]) mode = M_ABS;
                    3'b101:  if (aaa == 3'b100 || aaa == 3'b101) mode = M_ZPX;
                    3'b111:  if (aaa == 3'b101) mode = M_ABSX;
                    default: mode = M_IMP;
                endcase
            end
            2'b10: begin
                // STX/LDX swap X for Y as their index register
                case (bbb)
                    3'b000:  if (aaa == 3'b101) mode = M_IMM;
                    3'b001:  mode = M_ZP;
                    3'b011:  mode = M_ABS;
                    3'b101:  mode = (aaa == 3'b100 || aaa == 3'b101) ? M_ZPY : M_ZPX;
                    3'b111: begin
                        if (aaa == 3'b101)      mode = M_ABSY;
                        else if (aaa != 3'b100) mode = M_ABSX;
                    end
                    default: mode = M_IMP;
                endcase
            end
            default: mode = M_IMP;
        endcase
    end
endmodule

// File: rtl/addr_mode_sequencer.sv
// Per-instruction addressing cycle sequencer; Moore outputs from state + latched mode/class.
// rdy=0 freezes state/mode/class and forces all strobes low for that cycle.
module addr_mode_sequencer
    import cpu_pkg::*;
#(
    parameter bit PAGE_PENALTY = 1'b1,
    parameter bit ZP_WRAP      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    addr_mode_sequencer_if.master  bus
);
    state_t    state, state_nxt;
    mode_t     mode, mode_dec;
    op_class_t cls, cls_dec;
    strobe_t   stb, stb_g;
    addr_sel_t asel;
    logic      rw;
    logic      fix_needed;

    addr_mode_decode u_decode (
        .opcode   (bus.opcode),
        .mode     (mode_dec),
        .op_class (cls_dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
            mode  <= M_IMP;
            cls   <= CLS_RD;
        end else if (bus.rdy) begin
            state <= state_nxt;
            if (state == ST_FETCH) begin
                mode <= mode_dec;
                cls  <= cls_dec;
            end
        end
    end

    // Stores always take the fix cycle so the write never lands on the wrong page
    assign fix_needed = (cls == CLS_WR) || !PAGE_PENALTY || bus.page_cross;

    always_comb begin
        state_nxt = state;
        stb       = '0;
        asel      = AS_PC;
        rw        = 1'b0;
        case (state)
            ST_FETCH: begin
                stb.instruction_load = 1'b1;
                stb.increment_pc     = 1'b1;
                case (mode_dec)
                    M_IMP:                  state_nxt = ST_FETCH;
                    M_IMM:                  state_nxt = ST_IMM0;
                    M_ABS, M_ABSX, M_ABSY:  state_nxt = ST_ABS0;
                    default:                state_nxt = ST_ZP0;
                endcase
            end
            ST_IMM0: begin
                stb.increment_pc = 1'b1;
                stb.reg_load     = 1'b1;
                state_nxt        = ST_FETCH;
            end
            ST_ZP0: begin
                stb.increment_pc = 1'b1;
                if (mode == M_INDX || mode == M_INDY) stb.indirl_load = 1'b1;
                else                                  stb.dirl_load   = 1'b1;
                case (mode)
                    M_ZP:    state_nxt = ST_EXEC;
                    M_INDX:  state_nxt = ST_IX1;
                    M_INDY:  state_nxt = ST_IY1;
                    default: state_nxt = ST_ZPIDX;
                endcase
            end
            ST_ZPIDX: begin
                asel          = AS_ZERO;
                stb.dirl_load = 1'b1;
                stb.index_add = 1'b1;
                stb.dirh_load = !ZP_WRAP;
                state_nxt     = ST_EXEC;
            end
            ST_ABS0: begin
                stb.dirl_load    = 1'b1;
                stb.increment_pc = 1'b1;
                stb.index_add    = (mode != M_ABS);
                state_nxt        = ST_ABS1;
            end
            ST_ABS1: begin
                stb.dirh_load    = 1'b1;
                stb.increment_pc = 1'b1;
                state_nxt        = (mode != M_ABS && fix_needed) ? ST_FIX : ST_EXEC;
            end
            ST_IX1: begin
                asel            = AS_ZERO;
                stb.indirl_load = 1'b1;
                stb.index_add   = 1'b1;
                state_nxt       = ST_IX2;
            end
            ST_IX2: begin
                asel          = AS_INDIR;
                stb.dirl_load = 1'b1;
                state_nxt     = ST_IX3;
            end
            ST_IX3: begin
                asel          = AS_INDIR;
                stb.dirh_load = 1'b1;
                state_nxt     = ST_EXEC;
            end
            ST_IY1: begin
                asel          = AS_INDIR;
                stb.dirl_load = 1'b1;
                stb.index_add = 1'b1;
                state_nxt     = ST_IY2;
            end
            ST_IY2: begin
                asel          = AS_INDIR;
                stb.dirh_load = 1'b1;
                state_nxt     = fix_needed ? ST_FIX : ST_EXEC;
            end
            ST_FIX: begin
                asel         = AS_ABS;
                stb.dirh_inc = 1'b1;
                state_nxt    = ST_EXEC;
            end
            ST_EXEC: begin
                asel         = (mode == M_ZP || mode == M_ZPX || mode == M_ZPY) ? AS_ZERO : AS_ABS;
                rw           = (cls == CLS_WR);
                stb.reg_load = (cls == CLS_RD);
                state_nxt    = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    assign stb_g = bus.rdy ? stb : '0;

    assign bus.instruction_load = stb_g.instruction_load;
    assign bus.increment_pc     = stb_g.increment_pc;
    assign bus.dirl_load        = stb_g.dirl_load;
    assign bus.dirh_load        = stb_g.dirh_load;
    assign bus.indirl_load      = stb_g.indirl_load;
    assign bus.indirh_load      = stb_g.indirh_load;
    assign bus.index_add        = stb_g.index_add;
    assign bus.dirh_inc         = stb_g.dirh_inc;
    assign bus.reg_load         = stb_g.reg_load;
    assign bus.index_sel        = uses_y(mode);
    assign bus.read_write       = rw;
    assign bus.address_select   = asel;
    assign bus.sync             = (state == ST_FETCH);
endmodule

// File: tb/tb_addr_mode_sequencer.sv
// Directed vector bench: default-parameter instance plus PAGE_PENALTY=0/ZP_WRAP=0 instance,
// with a hand-driven asynchronous reset abandoning an instruction mid-sequence.
module tb_addr_mode_sequencer;
    localparam logic [8:0] IL  = 9'h100, IPC = 9'h080, DL  = 9'h040, DH = 9'h020,
                           IDL = 9'h010, IDH = 9'h008, IA  = 9'h004, DHI = 9'h002,
                           RL  = 9'h001, NO = 9'h000;
    localparam logic [7:0] J = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n, rdy, page_cross;
    logic [7:0] opcode;

    always #5 clk = ~clk;

    addr_mode_sequencer_if bus0 ();
    addr_mode_sequencer_if bus1 ();

    assign bus0.opcode = opcode;  assign bus0.rdy = rdy;  assign bus0.page_cross = page_cross;
    assign bus1.opcode = opcode;  assign bus1.rdy = rdy;  assign bus1.page_cross = page_cross;

    addr_mode_sequencer #(.PAGE_PENALTY(1'b1), .ZP_WRAP(1'b1)) dut0 (.clk(clk), .rst(rst_n), .bus(bus0));
    addr_mode_sequencer #(.PAGE_PENALTY(1'b0), .ZP_WRAP(1'b0)) dut1 (.clk(clk), .rst(rst_n), .bus(bus1));

    // observed = {sync, address_select, read_write, index_sel, 9 strobes}
    logic [13:0] obs0, obs1;
    assign obs0 = {bus0.sync, bus0.address_select, bus0.read_write, bus0.index_sel,
                   bus0.instruction_load, bus0.increment_pc, bus0.dirl_load, bus0.dirh_load,
                   bus0.indirl_load, bus0.indirh_load, bus0.index_add, bus0.dirh_inc, bus0.reg_load};
    assign obs1 = {bus1.sync, bus1.address_select, bus1.read_write, bus1.index_sel,
                   bus1.instruction_load, bus1.increment_pc, bus1.dirl_load, bus1.dirh_load,
                   bus1.indirl_load, bus1.indirh_load, bus1.index_add, bus1.dirh_inc, bus1.reg_load};

    typedef struct {
        bit          u;
        bit          r;
        bit          rd;
        logic [7:0]  op;
        bit          pc;
        logic [13:0] exp;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [13:0] ex(bit s, bit [1:0] a, bit w, bit i, logic [8:0] st);
        return {s, a, w, i, st};
    endfunction

    function automatic void add(bit u, bit r, bit rd, logic [7:0] op, bit pc, logic [13:0] e);
        vec_t v;
        v.u = u; v.r = r; v.rd = rd; v.op = op; v.pc = pc; v.exp = e;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got sync/as/rw/isel/stb=%b expected %b", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] op, input string nm, input logic [13:0] e);
        @(negedge clk);
        rst_n = r; rdy = 1'b1; opcode = op; page_cross = 1'b0;
        #1;
        chk(nm, obs0, e);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; opcode = 8'hEA; page_cross = 1'b0;

        // reset state, with and without rdy
        add(0, 0, 1, 8'hEA, 0, ex(1, 0, 0, 0, IL | IPC));
        add(0, 0, 0, 8'hEA, 0, ex(1, 0, 0, 0, NO));
        // A9 LDA #imm
        add(0, 1, 1, 8'hA9, 0, ex(1, 0, 0, 0, IL | IPC));
        add(0, 1, 1, J,     0, ex(0, 0, 0, 0, IPC | RL));
        // BD LDA abs,X no page cross
        add(0, 1, 1, 8'hBD, 0, ex(1, 0, 0, 0, IL | IPC));
        add(0, 1, 1, J,     0, ex(0, 0, 0, 0, DL | IPC | IA));
        add(0, 1, 1, J,     0, ex(0, 0, 0, 0, DH | IPC));
        add(0, 1, 1, J,     0, ex(0, 2, 0, 0, RL));
        // BD with page cross
        add(0, 1, 1, 8'hBD, 0, ex(1, 0, 0, 0, IL | IPC));
        add(0, 1, 1, J,     0, ex(0, 0, 0, 0, DL | IPC | IA));
        add(0, 1, 1, J,     1, ex(0, 0, 0, 0, DH | IPC));
        add(0, 1, 1, J,     0, ex(0, 2, 0, 0, DHI));
        add(0, 1, 1, J,     0, ex(0, 2, 0, 0, RL));
        // 9D STA abs,X: fix cycle regardless of page cross
        add(0, 1, 1, 8'h9D, 0, ex(1, 0, 0, 0, IL | IPC));
        add(0, 1, 1, J,     0, ex(0, 0, 0, 0, DL | IPC | IA));
        add(0, 1, 1, J,     0, ex(0, 0, 0, 0, DH | IPC));
        add(0, 1, 1, J,     0, ex(0, 2, 0, 0, DHI));
        add(0, 1, 1, J,     0, ex(0, 2, 1, 0, NO));
        // A1 LDA (zp,X)
        add(0, 1, 1, 8'hA1, 0, ex(1, 0, 0, 0, IL | IPC));
        add(0, 1, 1, J,     0, ex(0, 0, 0, 0, IPC | IDL));
        add(0, 1, 1, J,     0, ex(0, 1, 0, 0, IDL | IA));
        add(0, 1, 1, J,     0, ex(0, 3, 0, 0, DL));
        add(0, 1, 1, J,     0, ex(0, 3, 0, 0, DH));
        add(0, 1, 1, J,     0, ex(0, 2, 0, 0, RL));
        // B6 LDX zp,Y (wraps in page 0: no dirh_load)
        add(0, 1, 1, 8'hB6, 0, ex(1, 0, 0, 0, IL | IPC));
        add(0, 1, 1, J,     0, ex(0, 0, 0, 1, IPC | DL));
        add(0, 1, 1, J,     0, ex(0, 1, 0, 1, DL | IA));
        add(0, 1, 1, J,     0, ex(0, 1, 0, 1, RL));
        // B1 LDA (zp),Y: two stall cycles in IY1, page cross
        add(0, 1, 1, 8'hB1, 0, ex(1, 0, 0, 1, IL | IPC));
        add(0, 1, 1, J,     0, ex(0, 0, 0, 1, IPC | IDL));
        add(0, 1, 0, J,     0, ex(0, 3, 0, 1, NO));
        add(0, 1, 0, J,     0, ex(0, 3, 0, 1, NO));
        add(0, 1, 1, J,     0, ex(0, 3, 0, 1, DL | IA));
        add(0, 1, 1, J,     1, ex(0, 3, 0, 1, DH));
        add(0, 1, 1, J,     0, ex(0, 2, 0, 1, DHI));
        add(0, 1, 1, J,     0, ex(0, 2, 0, 1, RL));
        // stall in FETCH must not latch 9D; then EA (implied) and 85 STA zp
        add(0, 1, 0, 8'h9D, 0, ex(1, 0, 0, 1, NO));
        add(0, 1, 1, 8'hEA, 0, ex(1, 0, 0, 1, IL | IPC));
        add(0, 1, 1, 8'h85, 0, ex(1, 0, 0, 0, IL | IPC));
        add(0, 1, 1, J,     0, ex(0, 0, 0, 0, IPC | DL));
        add(0, 1, 1, J,     0, ex(0, 1, 1, 0, NO));
        // undefined 02 runs back-to-back fetches
        add(0, 1, 1, 8'h02, 0, ex(1, 0, 0, 0, IL | IPC));
        add(0, 1, 1, 8'hEA, 0, ex(1, 0, 0, 0, IL | IPC));
        // 8D STA abs: page_cross ignored, stalled write holds read_write
        add(0, 1, 1, 8'h8D, 0, ex(1, 0, 0, 0, IL | IPC));
        add(0, 1, 1, J,     0, ex(0, 0, 0, 0, DL | IPC));
        add(0, 1, 1, J,     1, ex(0, 0, 0, 0, DH | IPC));
        add(0, 1, 0, J,     0, ex(0, 2, 1, 0, NO));
        add(0, 1, 1, J,     0, ex(0, 2, 1, 0, NO));
        add(0, 1, 1, 8'hEA, 0, ex(1, 0, 0, 0, IL | IPC));
        // constant-timing / no-wrap instance
        add(1, 0, 1, 8'hEA, 0, ex(1, 0, 0, 0, IL | IPC));
        add(1, 1, 1, 8'hBD, 0, ex(1, 0, 0, 0, IL | IPC));
        add(1, 1, 1, J,     0, ex(0, 0, 0, 0, DL | IPC | IA));
        add(1, 1, 1, J,     0, ex(0, 0, 0, 0, DH | IPC));
        add(1, 1, 1, J,     0, ex(0, 2, 0, 0, DHI));
        add(1, 1, 1, J,     0, ex(0, 2, 0, 0, RL));
        add(1, 1, 1, 8'hB6, 0, ex(1, 0, 0, 0, IL | IPC));
        add(1, 1, 1, J,     0, ex(0, 0, 0, 1, IPC | DL));
        add(1, 1, 1, J,     0, ex(0, 1, 0, 1, DL | DH | IA));
        add(1, 1, 1, J,     0, ex(0, 1, 0, 1, RL));
        add(1, 1, 1, 8'hEA, 0, ex(1, 0, 0, 1, IL | IPC));

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst_n = vq[i].r; rdy = vq[i].rd; opcode = vq[i].op; page_cross = vq[i].pc;
            #1;
            chk($sformatf("vec%0d", i), vq[i].u ? obs1 : obs0, vq[i].exp);
        end

        // reset asserted during IX2 of A1, then A5 LDA zp
        @(negedge clk);
        rst_n = 1'b0; rdy = 1'b1; opcode = 8'hEA;
        step(1'b1, 8'hA1, "ix_fetch", ex(1, 0, 0, 0, IL | IPC));
        step(1'b1, J,     "ix_zp0",   ex(0, 0, 0, 0, IPC | IDL));
        step(1'b1, J,     "ix_ix1",   ex(0, 1, 0, 0, IDL | IA));
        step(1'b1, J,     "ix_ix2",   ex(0, 3, 0, 0, DL));
        #2 rst_n = 1'b0;
        #1 chk("async_rst", obs0, ex(1, 0, 0, 0, IL | IPC));
        step(1'b1, 8'hA5, "a5_fetch", ex(1, 0, 0, 0, IL | IPC));
        step(1'b1, J,     "a5_zp0",   ex(0, 0, 0, 0, IPC | DL));
        step(1'b1, J,     "a5_exec",  ex(0, 1, 0, 0, RL));
        step(1'b1, 8'hEA, "a5_next",  ex(1, 0, 0, 0, IL | IPC));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
